data_store_controller: RTL

Store-direction counterpart of the data-load controller. Accepts one simultaneous 16-bit store request from each of 16 cores and serialises them into read-modify-write operations on a 64-bit-row data memory. Each distinct memory row touched by the batch costs one read and one write. A single broadcast DONE pulse releases all cores together. Sits between the core array and the data memory write port, sharing the load path's row/lane address mapping.

---
 rtl/ds_pkg.sv | 36 +++
 rtl/ds_row_merge.sv | 49 ++++
 rtl/data_store_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ds_pkg
//  Purpose  : Shared types, constants and address-mapping helpers for the
//             data store controller (row/lane map matches the load path).
//  Contents : state_t   - controller state encoding
//             ROW_W     - memory row width (4 lanes of 16 bits)
//             LANES     - lanes per row
//             row_of()  - word address -> row address
//             lane_of() - word address -> lane index (0 = bits [63:48])
//  Revision : 1.0 - initial release
// ============================================================================
package ds_pkg;

  localparam int ROW_W = 64;
  localparam int LANES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  function automatic logic [15:0] row_of(input logic [15:0] a);
    return {2'b00, a[15:2]};
  endfunction

  // Lane 0 is the most significant 16 bits of the row.
  function automatic logic [1:0] lane_of(input logic [15:0] a);
    return a[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ds_row_merge.sv
`default_nettype none
// ============================================================================
//  Module   : ds_row_merge
//  Purpose  : Combinational merge of all pending store words that fall in the
//             leader's row into the row read back from memory.
//  Ports    : i_mem_rdata    - row currently returned by memory
//             i_words        - latched store data, core i at [16i+15:16i]
//             i_addrs        - latched word addresses, same packing
//             i_pending      - cores whose store is not yet written
//             i_leader_row   - row being written this RD/WR pair
//             o_merged       - row to write back
//             o_merged_mask  - cores whose store is contained in o_merged
//  Revision : 1.0 - initial release
// ============================================================================
module ds_row_merge
  import ds_pkg::*;
#(
  parameter int N_CORES = 16,
  parameter int WORD_W  = 16
) (
  input  logic [ROW_W-1:0]          i_mem_rdata,
  input  logic [N_CORES*WORD_W-1:0] i_words,
  input  logic [N_CORES*WORD_W-1:0] i_addrs,
  input  logic [N_CORES-1:0]        i_pending,
  input  logic [WORD_W-1:0]         i_leader_row,
  output logic [ROW_W-1:0]          o_merged,
  output logic [N_CORES-1:0]        o_merged_mask
);

  // Ascending core order: a later (higher-index) core overwrites an earlier
  // one in the same lane, so the highest index wins a lane collision.
  always_comb begin
    o_merged      = i_mem_rdata;
    o_merged_mask = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (i_pending[i] && (row_of(i_addrs[i*WORD_W +: WORD_W]) == i_leader_row)) begin
        o_merged_mask[i] = 1'b1;
        case (lane_of(i_addrs[i*WORD_W +: WORD_W]))
          2'd0:    o_merged[ROW_W-1            -: WORD_W] = i_words[i*WORD_W +: WORD_W];
          2'd1:    o_merged[ROW_W-1-WORD_W     -: WORD_W] = i_words[i*WORD_W +: WORD_W];
          2'd2:    o_merged[ROW_W-1-2*WORD_W   -: WORD_W] = i_words[i*WORD_W +: WORD_W];
          default: o_merged[ROW_W-1-3*WORD_W   -: WORD_W] = i_words[i*WORD_W +: WORD_W];
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_store_controller.sv
`default_nettype none
// ============================================================================
//  Module   : data_store_controller
//  Purpose  : Serialises one simultaneous store from each core into
//             read-modify-write row operations, one RD/WR pair per distinct
//             row, then pulses DONE to release all cores together.
//  Ports    : clk, rst_n         - clock / async active-low reset
//             MW, MADDR, DIN     - per-core request, word address, data
//             mem_rdata          - row read data (valid cycle after MEMREAD)
//             MEMREAD, MEMWRITE  - row read / write strobes
//             MEMADDR, MEMWDATA  - row address and merged write data
//             BUSY, DONE         - batch in progress / completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module data_store_controller
  import ds_pkg::*;
#(
  parameter int N_CORES = 16,
  parameter int WORD_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        MW,
  input  logic [N_CORES*WORD_W-1:0] MADDR,
  input  logic [N_CORES*WORD_W-1:0] DIN,
  input  logic [ROW_W-1:0]          mem_rdata,
  output logic                      MEMREAD,
  output logic                      MEMWRITE,
  output logic [WORD_W-1:0]         MEMADDR,
  output logic [ROW_W-1:0]          MEMWDATA,
  output logic                      BUSY,
  output logic                      DONE
);

  state_t                    r_state;
  logic [N_CORES-1:0]        r_pending;
  logic [N_CORES*WORD_W-1:0] r_addrs;
  logic [N_CORES*WORD_W-1:0] r_words;

  logic                      w_all_req;
  logic [WORD_W-1:0]         w_leader_row;
  logic [ROW_W-1:0]          w_merged;
  logic [N_CORES-1:0]        w_merged_mask;
  logic [N_CORES-1:0]        w_pending_left;

  assign w_all_req = &MW;

  // Priority encoder: scanning downwards leaves the lowest pending core's
  // row as leader, giving ascending leader-index processing order.
  always_comb begin
    w_leader_row = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_leader_row = row_of(r_addrs[i*WORD_W +: WORD_W]);
      end
    end
  end

  ds_row_merge #(
    .N_CORES (N_CORES),
    .WORD_W  (WORD_W)
  ) u_row_merge (
    .i_mem_rdata   (mem_rdata),
    .i_words       (r_words),
    .i_addrs       (r_addrs),
    .i_pending     (r_pending),
    .i_leader_row  (w_leader_row),
    .o_merged      (w_merged),
    .o_merged_mask (w_merged_mask)
  );

  assign w_pending_left = r_pending & ~w_merged_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_addrs   <= '0;
      r_words   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_all_req) begin
            r_addrs   <= MADDR;
            r_words   <= DIN;
            r_pending <= '1;
            r_state   <= ST_RD;
          end
        end
        ST_RD: begin
          r_state <= ST_WR;
        end
        ST_WR: begin
          r_pending <= w_pending_left;
          r_state   <= (w_pending_left == '0) ? ST_DONE : ST_RD;
        end
        ST_DONE: begin
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // A request still held from the finished batch must not restart it.
          if (!w_all_req) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs: everything is gated by state, so an asynchronous reset
  // clears all strobes and buses immediately.
  assign MEMREAD  = (r_state == ST_RD);
  assign MEMWRITE = (r_state == ST_WR);
  assign DONE     = (r_state == ST_DONE);
  assign BUSY     = (r_state == ST_RD) || (r_state == ST_WR) || (r_state == ST_DONE);
  assign MEMADDR  = (MEMREAD || MEMWRITE) ? w_leader_row : '0;
  assign MEMWDATA = MEMWRITE ? w_merged : '0;

endmodule
`default_nettype wire
